mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL declare parameter MULT_CYCLES, default 5, meaning Busy duration for mult/multu.
REQ-002 SHALL declare parameter DIV_CYCLES, default 10, meaning Busy duration for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin a mult/multu/div/divu operation.
REQ-006 SHALL have port MulDiv_Type  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port MulDiv_Write  input  2  direct write: 01 mthi, 10 mtlo, 00/11 none.
REQ-008 SHALL have port A  input  32  rs operand, forwarded value from EX stage.
REQ-009 SHALL have port B  input  32  rt operand, forwarded value from EX stage.
REQ-010 SHALL have port Busy  output  1  operation in progress, used by the hazard unit to stall mfhi/mflo/mthi/mtlo/mult/div.
REQ-011 SHALL have port HI  output  32  registered HI value.
REQ-012 SHALL have port LO  output  32  registered LO value.

Function
REQ-013 SHALL be a two-state machine: IDLE and RUN, with a down-counter cnt sized for the larger of MULT_CYCLES and DIV_CYCLES.
REQ-014 In IDLE, Start=1 at an edge SHALL capture A, B and MulDiv_Type, load cnt with MULT_CYCLES (Type 0x) or DIV_CYCLES (Type 1x), and enter RUN.
REQ-015 mult SHALL compute the signed 64-bit product, multu the unsigned 64-bit product; {HI,LO} = product.
REQ-016 div/divu SHALL give LO = quotient and HI = remainder, signed division truncating toward zero with the remainder carrying the dividend's sign; divu is unsigned.
REQ-017 Division with B == 0 SHALL leave HI and LO unchanged but still occupy RUN for DIV_CYCLES cycles.
REQ-018 In RUN, cnt SHALL decrement on each edge; on the edge where cnt goes from 1 to 0, HI/LO SHALL take the result and the state SHALL return to IDLE.
REQ-019 Net latency: HI/LO SHALL update exactly N edges after the Start edge (N = MULT_CYCLES or DIV_CYCLES); the registered busy bit SHALL be high for exactly N cycles.
REQ-020 The result SHALL depend only on operands captured at the Start edge; A/B changes during RUN SHALL have no effect.
REQ-021 Start asserted during RUN SHALL be ignored.
REQ-022 In IDLE, with Start=0, MulDiv_Write=01 SHALL load HI<=A and 10 SHALL load LO<=A at the edge; the other register SHALL hold.
REQ-023 MulDiv_Write SHALL be ignored when Start=1 or when in RUN.
REQ-024 HI/LO SHALL hold their value in every cycle with no write and no completion.

Reset
REQ-025 reset=1 SHALL immediately, independent of clk, force state=IDLE, cnt=0, HI=0, LO=0, Busy=0 and clear the captured operands.
REQ-026 reset during RUN SHALL abort the operation; no result SHALL be written after release.
REQ-027 The first edge after reset deasserts SHALL accept Start or MulDiv_Write normally.

Configuration
REQ-028 Macro MULDIV_START_BUSY_EN defined: Busy SHALL equal (Start & ~reset) | registered busy bit, so a mfhi/mflo immediately behind mult/div stalls in the Start cycle.
REQ-029 Macro MULDIV_START_BUSY_EN undefined: Busy SHALL equal the registered busy bit only, and the hazard unit treats Start separately.

Verification
REQ-030 Reset, then Start, Type=00, A=0xFFFFFFFF, B=2 -> Busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE after the 5th edge.
REQ-031 Start, Type=01, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 edges.
REQ-032 Start, Type=10, A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; repeat with Type=11, A=7, B=2 -> LO=3, HI=1.
REQ-033 HI=0x11, LO=0x22 preloaded via mthi/mtlo; div with B=0 -> Busy 10 cycles, HI=0x11, LO=0x22 unchanged; mthi with A=0x55 and second Start issued mid-RUN -> both ignored.
REQ-034 Start mult, assert reset at cycle 3 -> HI=LO=0 and Busy=0 immediately; nothing changes at cycle 5.
REQ-035 Sample Busy in the Start cycle with and without MULDIV_START_BUSY_EN -> 1 and 0 respectively; identical HI/LO in both builds.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Optional macro MULDIV_START_BUSY_EN: Busy also reflects Start in the issue cycle.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MulDiv_Type,
  input  logic [1:0]  MulDiv_Write,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       op_a, op_a_n, op_b, op_b_n;
  logic [1:0]        op_type, op_type_n;
  logic [31:0]       hi_n, lo_n;
  logic              busy_r;

  logic [63:0]        mul_a, mul_b, prod;
  logic signed [31:0] s_a, s_b;
  logic [31:0]        quot, rem;

  // Sign-extending (or zero-extending) to 64 bits lets one modulo-2^64 multiplier serve both mult and multu.
  always_comb begin
    mul_a = {{32{op_a[31] & ~op_type[0]}}, op_a};
    mul_b = {{32{op_b[31] & ~op_type[0]}}, op_b};
    prod  = mul_a * mul_b;
    s_a   = op_a;
    s_b   = op_b;
    quot  = '0;
    rem   = '0;
    if (op_b != '0) begin
      if (op_type[0]) begin
        quot = op_a / op_b;
        rem  = op_a % op_b;
      end else begin
        quot = s_a / s_b;
        rem  = s_a % s_b;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    op_a_n    = op_a;
    op_b_n    = op_b;
    op_type_n = op_type;
    hi_n      = HI;
    lo_n      = LO;
    case (state)
      IDLE: begin
        if (Start) begin
          op_a_n    = A;
          op_b_n    = B;
          op_type_n = MulDiv_Type;
          cnt_n     = MulDiv_Type[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_n   = RUN;
        end else if (MulDiv_Write == 2'b01) begin
          hi_n = A;
        end else if (MulDiv_Write == 2'b10) begin
          lo_n = A;
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (!op_type[1]) begin
            {hi_n, lo_n} = prod;
          end else if (op_b != '0) begin
            hi_n = rem;
            lo_n = quot;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_type <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_a    <= op_a_n;
      op_b    <= op_b_n;
      op_type <= op_type_n;
      HI      <= hi_n;
      LO      <= lo_n;
    end
  end

  assign busy_r = (state == RUN);

`ifdef MULDIV_START_BUSY_EN
  assign Busy = (Start & ~reset) | busy_r;
`else
  assign Busy = busy_r;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit against an arithmetic HI/LO model.
// Honours MULDIV_START_BUSY_EN for the issue-cycle Busy expectation.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MulDiv_Type;
  logic [1:0]  MulDiv_Write;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

`ifdef MULDIV_START_BUSY_EN
  localparam logic START_BUSY = 1'b1;
`else
  localparam logic START_BUSY = 1'b0;
`endif

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MulDiv_Type(MulDiv_Type),
    .MulDiv_Write(MulDiv_Write), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: architectural HI/LO effect of one operation, from plain integer arithmetic.
  task automatic model_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, ma, mb, q, r;
    logic [63:0] p;
    case (t)
      2'b00: begin
        p = longint'(int'(a)) * longint'(int'(b));
        {hi_m, lo_m} = p;
      end
      2'b01: begin
        p = 64'(a) * 64'(b);
        {hi_m, lo_m} = p;
      end
      2'b10: if (b != 0) begin
        na = int'(a);
        nb = int'(b);
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        q  = ma / mb;
        r  = ma - q * mb;
        if ((na < 0) != (nb < 0)) q = -q;
        if (na < 0) r = -r;
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      default: if (b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end
    endcase
  endtask

  task automatic write_reg(input logic [1:0] w, input logic [31:0] a);
    @(negedge clk);
    Start = 1'b0;
    MulDiv_Write = w;
    A = a;
    @(posedge clk);
    #1;
    MulDiv_Write = 2'b00;
    if (w == 2'b01) hi_m = a;
    if (w == 2'b10) lo_m = a;
    check("wr_hi", HI, hi_m);
    check("wr_lo", LO, lo_m);
  endtask

  task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input bit noisy);
    int n;
    logic [31:0] old_hi, old_lo;
    n = t[1] ? 10 : 5;
    old_hi = hi_m;
    old_lo = lo_m;
    model_op(t, a, b);
    @(negedge clk);
    Start = 1'b1;
    MulDiv_Type = t;
    A = a;
    B = b;
    MulDiv_Write = noisy ? 2'($urandom) : 2'b00;
    #1;
    check("busy_start", Busy, START_BUSY);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i < n && noisy) begin
        Start = 1'($urandom);
        MulDiv_Type = 2'($urandom);
        MulDiv_Write = 2'($urandom);
        A = $urandom;
        B = $urandom;
      end else begin
        Start = 1'b0;
        MulDiv_Write = 2'b00;
      end
      #1;
      check("busy_run", Busy, (i < n) ? 1 : 0);
      check("op_hi", HI, (i < n) ? old_hi : hi_m);
      check("op_lo", LO, (i < n) ? old_lo : lo_m);
    end
  endtask

  initial begin
    logic [1:0] t;
    logic [31:0] a, b;
    reset = 1'b0;
    Start = 1'b0;
    MulDiv_Type = 2'b00;
    MulDiv_Write = 2'b00;
    A = '0;
    B = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", Busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_hi", HI, 32'hFFFFFFFF);
    check("div_lo", LO, 32'hFFFFFFFD);
    run_op(2'b11, 32'd7, 32'd2, 1'b0);
    check("divu_hi", HI, 32'd1);
    check("divu_lo", LO, 32'd3);

    write_reg(2'b01, 32'h11);
    write_reg(2'b10, 32'h22);
    run_op(2'b10, 32'h1234, 32'd0, 1'b1);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);

    // Abort a multiply with reset partway through.
    @(negedge clk);
    Start = 1'b1;
    MulDiv_Type = 2'b00;
    A = 32'h1234;
    B = 32'h5678;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    hi_m = '0;
    lo_m = '0;
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    check("abort_busy", Busy, 0);
    @(negedge clk);
    reset = 1'b0;
    MulDiv_Write = 2'b10;
    A = 32'hABCD;
    @(posedge clk);
    #1 MulDiv_Write = 2'b00;
    lo_m = 32'hABCD;
    check("post_rst_lo", LO, 32'hABCD);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_hold_hi", HI, hi_m);
      check("abort_hold_lo", LO, lo_m);
      check("abort_hold_busy", Busy, 0);
    end

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        write_reg(2'($urandom), $urandom);
      end else begin
        t = 2'($urandom);
        a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 100) : $urandom;
        case ($urandom_range(0, 7))
          0:       b = 32'd0;
          1:       b = 32'hFFFFFFFF;
          2:       b = $urandom_range(1, 9);
          default: b = $urandom;
        endcase
        if (t == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
        run_op(t, a, b, 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
